// File: rtl/led_sched_pkg.sv
// Shared state encoding and elaboration-time sizing helpers for the LED refresh scheduler.
package led_sched_pkg;

    typedef enum logic [2:0] {IDLE, SWAP, START, RUN, LATCH} state_t;

    // Cycles RUN always lasts so drivers have time to raise busy after start.
    localparam int RUN_GRACE = 4;

    // Bits needed for a counter that takes values 0..n-1.
    function automatic int cnt_w(input longint n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tick_div(input longint clk_hz, input longint rate_hz);
        return int'(clk_hz / rate_hz);
    endfunction

    function automatic int latch_cyc(input longint us, input longint clk_hz);
        return int'((us * clk_hz + 999_999) / 1_000_000);
    endfunction

    // Saturation point of the RUN counter: the watchdog limit when it is enabled.
    function automatic int run_limit(input longint wdog_cyc, input bit wdog_en);
        return (wdog_en && wdog_cyc > RUN_GRACE) ? int'(wdog_cyc) : RUN_GRACE;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running rate divider: one-cycle tick every DIV clocks, on the counter wrap.
module led_tick_gen
    import led_sched_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int W = cnt_w(DIV);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/led_refresh_scheduler.sv
// Frame refresh scheduler for addressable-LED strip drivers with a double-buffered colour RAM.
// Define LED_SCHED_WDOG_EN to compile in the RUN-state watchdog and the sticky fault flag.
module led_refresh_scheduler
    import led_sched_pkg::*;
#(
    parameter int CLOCK_FRQ  = 50_000_000,
    parameter int REFRESH_HZ = 60,
    parameter int LATCH_US   = 80,
    parameter int STRIPS     = 2,
    parameter int WDOG_CYC   = 1_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              commit,
    output logic              commit_ack,
    output logic              rd_bank,
    output logic              wr_bank,
    output logic [STRIPS-1:0] start,
    input  logic [STRIPS-1:0] busy,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              fault
);
    localparam int TICK_DIV  = tick_div(CLOCK_FRQ, REFRESH_HZ);
    localparam int LATCH_CYC = latch_cyc(LATCH_US, CLOCK_FRQ);
`ifdef LED_SCHED_WDOG_EN
    localparam bit WDOG_EN   = 1'b1;
`else
    localparam bit WDOG_EN   = 1'b0;
`endif
    localparam int RUN_LIMIT = run_limit(WDOG_CYC, WDOG_EN);
    localparam int RUN_W     = cnt_w(RUN_LIMIT + 2);
    localparam int LATCH_W   = cnt_w(LATCH_CYC);

    state_t             state;
    logic               tick;
    logic               pending;
    logic [RUN_W-1:0]   run_cnt;
    logic [RUN_W-1:0]   run_next;
    logic [LATCH_W-1:0] latch_cnt;
    logic               run_done;
    logic               wdog_hit;
    logic               fault_q;

    led_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign run_next = run_cnt + RUN_W'(1);
    assign run_done = (run_next >= RUN_W'(RUN_GRACE)) && (busy == '0);
`ifdef LED_SCHED_WDOG_EN
    assign wdog_hit = (run_next >= RUN_W'(WDOG_CYC));
`else
    assign wdog_hit = 1'b0;
`endif
    assign wr_bank = ~rd_bank;
    assign fault   = fault_q;

    // Outputs are registered on entry to a state, so start/commit_ack appear one cycle after the decision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            start      <= '0;
            commit_ack <= 1'b0;
            pending    <= 1'b0;
            run_cnt    <= '0;
            latch_cnt  <= '0;
            overrun    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            start      <= '0;
            commit_ack <= 1'b0;
            pending    <= pending | commit;

            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        if (pending) begin
                            state      <= SWAP;
                            rd_bank    <= ~rd_bank;
                            commit_ack <= 1'b1;
                        end else begin
                            state <= START;
                            start <= '1;
                        end
                    end
                end
                SWAP: begin
                    // The commit taken here is consumed; one arriving in this cycle re-arms the next swap.
                    pending <= commit;
                    state   <= START;
                    start   <= '1;
                end
                START: begin
                    state   <= RUN;
                    run_cnt <= '0;
                end
                RUN: begin
                    if (run_cnt != RUN_W'(RUN_LIMIT)) begin
                        run_cnt <= run_next;
                    end
                    if (wdog_hit) begin
                        fault_q   <= 1'b1;
                        state     <= LATCH;
                        latch_cnt <= '0;
                    end else if (run_done) begin
                        state     <= LATCH;
                        latch_cnt <= '0;
                    end
                end
                LATCH: begin
                    if (latch_cnt == LATCH_W'(LATCH_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + LATCH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
